serial_defaults_loader: RTL and testbench



---
 rtl/serial_loader_pkg.sv | 14 +
 rtl/serial_phase_timer.sv | 37 +++
 rtl/serial_defaults_loader.sv | 138 +++++++++++++
 tb/tb_serial_defaults_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_loader_pkg.sv
// Shared types and default geometry for the serial configuration-chain loader.
package serial_loader_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LOAD     = 2'd3
    } state_e;

    localparam int NUM_BLOCKS_DEF     = 2;
    localparam int BITS_PER_BLOCK_DEF = 13;

endpackage

// File: rtl/serial_phase_timer.sv
// Counts CLK_DIV cycles per serial_clock phase and ticks phase_end on the last one.
module serial_phase_timer #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic resetb,
    input  logic reload,
    input  logic enable,
    output logic phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign phase_end = enable && (cnt_q == '0);

    // The counter restarts at every phase boundary, so it never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (reload || phase_end) begin
            cnt_d = LAST;
        end else if (enable) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_defaults_loader.sv
// Snapshots the strapped default words on start, shifts them MSB-first down the
// serial configuration chain, then strobes serial_load so every block latches.
module serial_defaults_loader
    import serial_loader_pkg::*;
#(
    parameter int NUM_BLOCKS     = NUM_BLOCKS_DEF,
    parameter int BITS_PER_BLOCK = BITS_PER_BLOCK_DEF,
    parameter int CLK_DIV        = 1
) (
    input  logic                               clk,
    input  logic                               resetb,
    input  logic                               start,
    input  logic                               abort,
    input  logic [NUM_BLOCKS*BITS_PER_BLOCK-1:0] defaults,
    output logic                               busy,
    output logic                               done,
    output logic                               aborted,
    output logic                               serial_clock,
    output logic                               serial_load,
    output logic                               serial_data_out,
    output logic                               serial_resetn
);

    localparam int T   = NUM_BLOCKS * BITS_PER_BLOCK;
    localparam int BCW = $clog2(T + 1);
    localparam logic [BCW-1:0] BITS_ALL = BCW'(T);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

    state_e           state_q, state_d;
    logic [T-1:0]     shift_q, shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             accept;
    logic             phase_end;

    logic busy_d, done_d, aborted_d, sclk_d, sload_d, sdo_d;
    logic busy_q, done_q, aborted_q, sclk_q, sload_q, sdo_q, sresetn_q;

    assign accept = (state_q == IDLE) && start && !abort;

    serial_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk       (clk),
        .resetb    (resetb),
        .reload    (accept),
        .enable    (state_q != IDLE),
        .phase_end (phase_end)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT_LO;
                    shift_d   = defaults;
                    bit_cnt_d = BITS_ALL;
                end
            end
            SHIFT_LO: begin
                if (phase_end) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    bit_cnt_d = bit_cnt_q - BIT_ONE;
                    if (bit_cnt_q == BIT_ONE) begin
                        state_d = LOAD;
                    end else begin
                        state_d = SHIFT_LO;
                        shift_d = shift_q << 1;
                    end
                end
            end
            LOAD: begin
                if (phase_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) state_d = IDLE;
    end

    // Outputs are decoded from the next state and registered, so they change
    // together with the state and no input reaches a pin combinationally.
    always_comb begin
        busy_d    = (state_d != IDLE);
        sclk_d    = (state_d == SHIFT_HI);
        sload_d   = (state_d == LOAD);
        sdo_d     = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && shift_d[T-1];
        done_d    = (state_q == LOAD) && (state_d == IDLE) && !abort;
        aborted_d = (state_q != IDLE) && abort;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            sclk_q    <= 1'b0;
            sload_q   <= 1'b0;
            sdo_q     <= 1'b0;
            sresetn_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            sclk_q    <= sclk_d;
            sload_q   <= sload_d;
            sdo_q     <= sdo_d;
            sresetn_q <= 1'b1;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign serial_clock    = sclk_q;
    assign serial_load     = sload_q;
    assign serial_data_out = sdo_q;
    assign serial_resetn   = sresetn_q;

endmodule

// File: tb/tb_serial_defaults_loader.sv
// Drives two loaders (CLK_DIV 1 and 3) with shared inputs and checks both against
// a cycle-offset reference model, a hand-written vector table and directed corners.
module tb_serial_defaults_loader;

    localparam int NB = 2;
    localparam int BPB = 4;
    localparam int T = NB * BPB;

    typedef struct packed {
        logic busy;
        logic done;
        logic aborted;
        logic sclk;
        logic sdo;
        logic load;
        logic resetn;
    } out_t;

    typedef struct {
        logic start;
        logic abort;
        logic busy;
        logic sclk;
        logic sdo;
        logic load;
        logic done;
    } vec_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [T-1:0] defaults = '0;
    logic [1:0] busy, done, aborted, sclk, sload, sdo, sresetn;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: per DUT, whether a load is active, the 1-based cycle offset
    // since acceptance, and the snapshotted word.
    logic       m_active [2];
    int         m_n      [2];
    logic [T-1:0] m_snap [2];
    logic       m_done   [2];
    logic       m_abt    [2];
    logic       m_rstn;

    always #5 clk = ~clk;

    serial_defaults_loader #(.NUM_BLOCKS(NB), .BITS_PER_BLOCK(BPB), .CLK_DIV(1)) u_div1 (
        .clk(clk), .resetb(resetb), .start(start), .abort(abort), .defaults(defaults),
        .busy(busy[0]), .done(done[0]), .aborted(aborted[0]), .serial_clock(sclk[0]),
        .serial_load(sload[0]), .serial_data_out(sdo[0]), .serial_resetn(sresetn[0])
    );

    serial_defaults_loader #(.NUM_BLOCKS(NB), .BITS_PER_BLOCK(BPB), .CLK_DIV(3)) u_div3 (
        .clk(clk), .resetb(resetb), .start(start), .abort(abort), .defaults(defaults),
        .busy(busy[1]), .done(done[1]), .aborted(aborted[1]), .serial_clock(sclk[1]),
        .serial_load(sload[1]), .serial_data_out(sdo[1]), .serial_resetn(sresetn[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic out_t expect_of(input int i);
        out_t e;
        int   d;
        d = div_of(i);
        e = '0;
        e.resetn  = m_rstn;
        e.done    = m_done[i];
        e.aborted = m_abt[i];
        if (m_active[i]) begin
            e.busy = 1'b1;
            if (m_n[i] <= 2 * d * T) begin
                e.sclk = (((m_n[i] - 1) % (2 * d)) >= d);
                e.sdo  = m_snap[i][T - 1 - (m_n[i] - 1) / (2 * d)];
            end else begin
                e.load = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic out_t actual_of(input int i);
        out_t a;
        a.busy = busy[i];
        a.done = done[i];
        a.aborted = aborted[i];
        a.sclk = sclk[i];
        a.sdo = sdo[i];
        a.load = sload[i];
        a.resetn = sresetn[i];
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_n[i] = 0;
            m_snap[i] = '0;
            m_done[i] = 1'b0;
            m_abt[i] = 1'b0;
        end
        m_rstn = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic rb);
        for (int i = 0; i < 2; i++) begin
            int d;
            d = div_of(i);
            m_done[i] = 1'b0;
            m_abt[i] = 1'b0;
            if (!rb) begin
                m_active[i] = 1'b0;
            end else if (m_active[i]) begin
                if (a) begin
                    m_active[i] = 1'b0;
                    m_abt[i] = 1'b1;
                end else begin
                    m_n[i]++;
                    if (m_n[i] > 2 * d * T + d) begin
                        m_active[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
            end else if (s && !a) begin
                m_active[i] = 1'b1;
                m_n[i] = 1;
                m_snap[i] = defaults;
            end
        end
        m_rstn = rb;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            out_t e;
            out_t a;
            e = expect_of(i);
            a = actual_of(i);
            check($sformatf("model.busy[div%0d]", div_of(i)), a.busy, e.busy);
            check($sformatf("model.done[div%0d]", div_of(i)), a.done, e.done);
            check($sformatf("model.aborted[div%0d]", div_of(i)), a.aborted, e.aborted);
            check($sformatf("model.sclk[div%0d]", div_of(i)), a.sclk, e.sclk);
            check($sformatf("model.sdo[div%0d]", div_of(i)), a.sdo, e.sdo);
            check($sformatf("model.load[div%0d]", div_of(i)), a.load, e.load);
            check($sformatf("model.resetn[div%0d]", div_of(i)), a.resetn, e.resetn);
        end
    endtask

    // One clock: inputs change at the falling edge, outputs compared 1ns after the rising edge.
    task automatic drive(input logic s, input logic a, input logic rb);
        @(negedge clk);
        start = s;
        abort = a;
        resetb = rb;
        @(posedge clk);
        model_step(s, a, rb);
        #1;
        compare_all();
    endtask

    task automatic cycle(input logic s, input logic a);
        drive(s, a, 1'b1);
    endtask

    // Called 1ns after a rising edge: asserts reset mid-cycle, checks the
    // asynchronous clear, then releases on the next cycle.
    task automatic async_reset();
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        compare_all();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_active[0] || m_active[1]) && n < 200) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        check("wait_idle.busy", busy, 2'b00);
    endtask

    function automatic vec_t mk(input logic s, input logic a, input logic b, input logic k,
                                input logic d, input logic l, input logic n);
        vec_t v;
        v.start = s; v.abort = a; v.busy = b; v.sclk = k; v.sdo = d; v.load = l; v.done = n;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [19];
        int edges, dones, loads, cnt, run, run_min, run_max;
        logic prev;
        logic [7:0] cap;

        // Entry i: inputs during cycle i, expected div1 outputs in cycle i+1 (defaults = A5).
        tbl[0]  = mk(1, 0, 1, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 1, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0, 1, 1, 1, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 1, 0, 0);
        tbl[11] = mk(0, 0, 1, 1, 1, 0, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 1, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 0, 1, 0, 0);
        tbl[15] = mk(0, 0, 1, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 1, 0, 0, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 1);
        tbl[18] = mk(1, 0, 1, 0, 1, 0, 0);

        model_reset();
        #1;
        compare_all();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("reset.resetn_after_release", sresetn, 2'b11);
        cycle(1'b0, 1'b0);

        // Basic load, start while busy (entry 5) and start in the done cycle (entry 18).
        defaults = 8'hA5;
        edges = 0;
        dones = 0;
        prev = 1'b0;
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].start, tbl[i].abort);
            check($sformatf("table[%0d].busy", i), busy[0], tbl[i].busy);
            check($sformatf("table[%0d].sclk", i), sclk[0], tbl[i].sclk);
            check($sformatf("table[%0d].sdo", i), sdo[0], tbl[i].sdo);
            check($sformatf("table[%0d].load", i), sload[0], tbl[i].load);
            check($sformatf("table[%0d].done", i), done[0], tbl[i].done);
            if (i < 18) begin
                if (sclk[0] && !prev) edges++;
                if (done[0]) dones++;
            end
            prev = sclk[0];
        end
        check("basic.clock_edges", edges, 8);
        check("basic.done_pulses", dones, 1);
        wait_idle();

        // Divided clock: phase lengths, load width and done latency on the CLK_DIV=3 instance.
        defaults = 8'hFF;
        cycle(1'b1, 1'b0);
        cnt = 1; loads = 0; edges = 0; prev = 1'b0;
        run = 0; run_min = 1000; run_max = 0;
        while (!done[1] && cnt < 200) begin
            if (sload[1]) begin
                loads++;
                if (run > 0) begin
                    run_min = (run < run_min) ? run : run_min;
                    run_max = (run > run_max) ? run : run_max;
                    run = 0;
                end
            end else if (busy[1]) begin
                if (sclk[1] && !prev) edges++;
                if (sclk[1] != prev && run > 0) begin
                    run_min = (run < run_min) ? run : run_min;
                    run_max = (run > run_max) ? run : run_max;
                    run = 0;
                end
                run++;
                prev = sclk[1];
            end
            cycle(1'b0, 1'b0);
            cnt++;
        end
        check("div3.done_cycle", cnt, 52);
        check("div3.load_cycles", loads, 3);
        check("div3.clock_edges", edges, 8);
        check("div3.phase_min", run_min, 3);
        check("div3.phase_max", run_max, 3);
        wait_idle();

        // Abort mid-shift at cycle 7.
        defaults = 8'h5A;
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("abort.pulse", aborted[0], 1'b1);
        check("abort.busy", busy[0], 1'b0);
        check("abort.sclk", sclk[0], 1'b0);
        loads = 0;
        dones = 0;
        repeat (25) begin
            cycle(1'b0, 1'b0);
            loads += int'(sload[0]);
            dones += int'(done[0]);
        end
        check("abort.no_load", loads, 0);
        check("abort.no_done", dones, 0);

        // Abort together with start in IDLE.
        cycle(1'b1, 1'b1);
        check("abort_start.busy", busy[0], 1'b0);
        check("abort_start.aborted", aborted[0], 1'b0);
        cycle(1'b0, 1'b0);
        check("abort_start.still_idle", busy, 2'b00);

        // Snapshot isolation: defaults cleared in cycle 3.
        defaults = 8'hA5;
        cycle(1'b1, 1'b0);
        cap = '0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 3) defaults = 8'h00;
            if (sclk[0]) cap = {cap[6:0], sdo[0]};
            cycle(1'b0, 1'b0);
        end
        check("snapshot.shifted_word", cap, 8'hA5);
        wait_idle();

        // Reset mid-load at cycle 9, then a fresh load.
        defaults = 8'h3C;
        cycle(1'b1, 1'b0);
        repeat (8) cycle(1'b0, 1'b0);
        async_reset();
        check("reset_mid.resetn", sresetn[0], 1'b1);
        check("reset_mid.busy", busy[0], 1'b0);
        check("reset_mid.done", done[0], 1'b0);
        defaults = 8'hC3;
        cycle(1'b1, 1'b0);
        dones = 0;
        cnt = 0;
        while (m_active[0] && cnt < 100) begin
            cycle(1'b0, 1'b0);
            dones += int'(done[0]);
            cnt++;
        end
        check("reset_mid.fresh_done", dones, 1);
        wait_idle();

        // Randomised traffic against the model.
        for (int r = 0; r < 1500; r++) begin
            logic s, a;
            s = ($urandom_range(7) == 0);
            a = ($urandom_range(29) == 0);
            if ($urandom_range(3) == 0) defaults = T'($urandom);
            if ($urandom_range(599) == 0) async_reset();
            else cycle(s, a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
